// File: rtl/dma_axis_pkg.sv
// Shared types and helpers for the DMA AXI-Stream tx multiplexer.
package dma_axis_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_PKT
    } state_t;

    localparam int SRC_FIELD_W = 8;
    localparam int MAX_CH      = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dma_axis_reg_slice.sv
// Two-entry FIFO skid slice; ready depends only on registered occupancy.
module dma_axis_reg_slice
    import dma_axis_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_data,
    input  logic         i_valid,
    output logic         o_ready,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    input  logic         i_ready
);

    logic [W-1:0] r_mem [2];
    logic         r_wr;
    logic         r_rd;
    logic [1:0]   r_cnt;
    logic         w_push;
    logic         w_pop;

    assign o_ready = (r_cnt != 2'd2);
    assign o_valid = (r_cnt != 2'd0);
    assign o_data  = r_mem[r_rd];
    assign w_push  = i_valid & o_ready;
    assign w_pop   = o_valid & i_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr     <= 1'b0;
            r_rd     <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= ~r_wr;
            end
            if (w_pop) begin
                r_rd <= ~r_rd;
            end
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule

// File: rtl/dma_axis_tx_rr_mux.sv
// N-channel packet round-robin AXI-Stream mux with TUSER source tagging.
// Define DMA_AXIS_TX_RR_MUX_STATS_EN to add per-channel packet counters.
module dma_axis_tx_rr_mux
    import dma_axis_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int DATA_WIDTH    = 64,
    parameter int TUSER_WIDTH   = 128,
    parameter int SRC_FIELD_LSB = 16
) (
    input  logic                           axi_clk,
    input  logic                           rst,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [NUM_CH*DATA_WIDTH/8-1:0] S_AXIS_TSTRB,
    input  logic [NUM_CH*TUSER_WIDTH-1:0]  S_AXIS_TUSER,
    input  logic [NUM_CH-1:0]              S_AXIS_TVALID,
    input  logic [NUM_CH-1:0]              S_AXIS_TLAST,
    output logic [NUM_CH-1:0]              S_AXIS_TREADY,
    output logic [DATA_WIDTH-1:0]          M_AXIS_TDATA,
    output logic [DATA_WIDTH/8-1:0]        M_AXIS_TSTRB,
    output logic [TUSER_WIDTH-1:0]         M_AXIS_TUSER,
    output logic                           M_AXIS_TVALID,
    output logic                           M_AXIS_TLAST,
    input  logic                           M_AXIS_TREADY
`ifdef DMA_AXIS_TX_RR_MUX_STATS_EN
    ,
    input  logic                           cnt_clr,
    output logic [NUM_CH*32-1:0]           pkt_cnt
`endif
);

    localparam int GW = (clog2(NUM_CH) > 0) ? clog2(NUM_CH) : 1;
    localparam int SW = DATA_WIDTH / 8;
    localparam int PW = DATA_WIDTH + SW + TUSER_WIDTH + 1;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [GW-1:0]          r_grant;
    logic [GW-1:0]          w_grant_nxt;
    logic [GW-1:0]          r_rr_ptr;
    logic [GW-1:0]          w_rr_nxt;
    logic [GW-1:0]          w_scan;
    logic [GW-1:0]          w_idx;
    logic                   w_any;
    logic                   w_sl_ready;
    logic                   w_in_valid;
    logic                   w_in_last;
    logic                   w_acc;
    logic [TUSER_WIDTH-1:0] w_user;
    logic [PW-1:0]          w_in_pkt;
    logic [PW-1:0]          w_out_pkt;

    // Descending scan so the channel nearest rr_ptr+1 is written last.
    always_comb begin
        w_any  = 1'b0;
        w_scan = r_rr_ptr;
        w_idx  = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            w_idx = GW'((int'(r_rr_ptr) + i) % NUM_CH);
            if (S_AXIS_TVALID[w_idx]) begin
                w_any  = 1'b1;
                w_scan = w_idx;
            end
        end
    end

    assign w_in_valid = (r_state == ST_PKT) & S_AXIS_TVALID[r_grant];
    assign w_in_last  = S_AXIS_TLAST[r_grant];
    assign w_acc      = w_in_valid & w_sl_ready;

    always_comb begin
        S_AXIS_TREADY = '0;
        if (r_state == ST_PKT) begin
            S_AXIS_TREADY[r_grant] = w_sl_ready;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_rr_nxt    = r_rr_ptr;
        unique case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_grant_nxt = w_scan;
                    w_state_nxt = ST_PKT;
                end
            end
            ST_PKT: begin
                if (w_acc && w_in_last) begin
                    w_rr_nxt    = r_grant;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge axi_clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= GW'(NUM_CH - 1);
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_rr_ptr <= w_rr_nxt;
        end
    end

    always_comb begin
        w_user = S_AXIS_TUSER[int'(r_grant)*TUSER_WIDTH +: TUSER_WIDTH];
        w_user[SRC_FIELD_LSB +: SRC_FIELD_W] = SRC_FIELD_W'(1) << r_grant;
    end

    assign w_in_pkt = {S_AXIS_TDATA[int'(r_grant)*DATA_WIDTH +: DATA_WIDTH],
                       S_AXIS_TSTRB[int'(r_grant)*SW +: SW],
                       w_user,
                       w_in_last};

    dma_axis_reg_slice #(
        .W(PW)
    ) u_slice (
        .i_clk   (axi_clk),
        .i_rst   (rst),
        .i_data  (w_in_pkt),
        .i_valid (w_in_valid),
        .o_ready (w_sl_ready),
        .o_data  (w_out_pkt),
        .o_valid (M_AXIS_TVALID),
        .i_ready (M_AXIS_TREADY)
    );

    assign {M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TUSER, M_AXIS_TLAST} = w_out_pkt;

`ifdef DMA_AXIS_TX_RR_MUX_STATS_EN
    logic [31:0] r_pkt_cnt [NUM_CH];

    always_ff @(posedge axi_clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_pkt_cnt[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (cnt_clr) begin
                    r_pkt_cnt[c] <= '0;
                end else if (w_acc && w_in_last && (r_grant == GW'(c))) begin
                    r_pkt_cnt[c] <= r_pkt_cnt[c] + 32'd1;
                end
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_cnt
        assign pkt_cnt[c*32 +: 32] = r_pkt_cnt[c];
    end
`endif

endmodule

// File: tb/tb_dma_axis_tx_rr_mux.sv
// Randomized bench for dma_axis_tx_rr_mux against a packet-level round-robin model.
// Define DMA_AXIS_TX_RR_MUX_STATS_EN to also exercise the packet counters.
module tb_dma_axis_tx_rr_mux;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int SW = DW / 8;
    localparam int UW = 128;
    localparam int SL = 16;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        logic [UW-1:0] u;
        logic          l;
    } beat_t;

    logic            axi_clk = 1'b0;
    logic            rst = 1'b1;
    logic [N*DW-1:0] s_tdata = '0;
    logic [N*SW-1:0] s_tstrb = '0;
    logic [N*UW-1:0] s_tuser = '0;
    logic [N-1:0]    s_tvalid = '0;
    logic [N-1:0]    s_tlast = '0;
    logic [N-1:0]    s_tready;
    logic [DW-1:0]   m_tdata;
    logic [SW-1:0]   m_tstrb;
    logic [UW-1:0]   m_tuser;
    logic            m_tvalid;
    logic            m_tlast;
    logic            m_tready = 1'b0;
`ifdef DMA_AXIS_TX_RR_MUX_STATS_EN
    logic            cnt_clr = 1'b0;
    logic [N*32-1:0] pkt_cnt;
`endif

    always #5 axi_clk = ~axi_clk;

    dma_axis_tx_rr_mux #(
        .NUM_CH        (N),
        .DATA_WIDTH    (DW),
        .TUSER_WIDTH   (UW),
        .SRC_FIELD_LSB (SL)
    ) dut (
        .axi_clk       (axi_clk),
        .rst           (rst),
        .S_AXIS_TDATA  (s_tdata),
        .S_AXIS_TSTRB  (s_tstrb),
        .S_AXIS_TUSER  (s_tuser),
        .S_AXIS_TVALID (s_tvalid),
        .S_AXIS_TLAST  (s_tlast),
        .S_AXIS_TREADY (s_tready),
        .M_AXIS_TDATA  (m_tdata),
        .M_AXIS_TSTRB  (m_tstrb),
        .M_AXIS_TUSER  (m_tuser),
        .M_AXIS_TVALID (m_tvalid),
        .M_AXIS_TLAST  (m_tlast),
        .M_AXIS_TREADY (m_tready)
`ifdef DMA_AXIS_TX_RR_MUX_STATS_EN
        ,
        .cnt_clr       (cnt_clr),
        .pkt_cnt       (pkt_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    beat_t src_q[N][$];
    int    plen_q[N][$];
    beat_t exp_q[$];
    int    acc_cyc_q[$];
    int    m_ptr = N - 1;
    int    occ = 0;
    bit    mid[N];
    bit    pend[N];
    int    cyc;
    int    n_acc;
    int    last_tl_cyc;
    bit    prev_stall = 0;
    beat_t prev_out;
    int    rdy_mode = 0;
    bit    gap_en = 0;
    bit    lat_chk = 0;
    bit    bub_chk = 0;
    bit    first_chk = 0;

    task automatic load_pkt(input int c, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d = {$urandom, $urandom};
            b.s = SW'($urandom);
            b.u = {$urandom, $urandom, $urandom, $urandom};
            b.l = (i == len - 1);
            src_q[c].push_back(b);
        end
        plen_q[c].push_back(len);
    endtask

    // Every loaded channel stays valid between packets, so each
    // arbitration sees exactly the channels with packets left.
    task automatic build_expected();
        int    off[N];
        bit    found;
        int    c;
        int    len;
        beat_t t;
        for (int k = 0; k < N; k++) off[k] = 0;
        do begin
            found = 0;
            for (int i = 1; i <= N && !found; i++) begin
                c = (m_ptr + i) % N;
                if (plen_q[c].size() > 0) begin
                    len = plen_q[c].pop_front();
                    for (int b = 0; b < len; b++) begin
                        t = src_q[c][off[c] + b];
                        t.u[SL +: 8] = 8'(1 << c);
                        exp_q.push_back(t);
                    end
                    off[c] += len;
                    m_ptr = c;
                    found = 1;
                end
            end
        end while (found);
    endtask

    task automatic drive();
        beat_t h;
        for (int c = 0; c < N; c++) begin
            if (src_q[c].size() > 0 &&
                (pend[c] || !(mid[c] && gap_en && $urandom_range(0, 2) == 0))) begin
                h = src_q[c][0];
                s_tvalid[c] = 1'b1;
                s_tdata[c*DW +: DW] = h.d;
                s_tstrb[c*SW +: SW] = h.s;
                s_tuser[c*UW +: UW] = h.u;
                s_tlast[c] = h.l;
            end else begin
                s_tvalid[c] = 1'b0;
                s_tdata[c*DW +: DW] = {$urandom, $urandom};
                s_tlast[c] = 1'($urandom);
            end
        end
        case (rdy_mode)
            0: m_tready = 1'b1;
            1: m_tready = ($urandom_range(0, 3) != 0);
            default: m_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
        endcase
    endtask

    task automatic sample();
        logic [N-1:0] acc;
        beat_t        cur;
        beat_t        h;
        int           a;
        acc = s_tvalid & s_tready;
        cur = {m_tdata, m_tstrb, m_tuser, m_tlast};
        chk("tready_onehot", ($countones(s_tready) <= 1), 1);
        chk("mvalid_occ", m_tvalid, (occ > 0));
        if (occ == 2) chk("tready_full", s_tready, 0);
        if (prev_stall) chk("stall_hold", {m_tvalid, cur}, {1'b1, prev_out});
        for (int c = 0; c < N; c++) begin
            pend[c] = s_tvalid[c] && !acc[c];
            if (acc[c]) begin
                h = src_q[c].pop_front();
                n_acc++;
                occ++;
                acc_cyc_q.push_back(cyc);
                if (first_chk && n_acc == 1) chk("first_acc_cyc", cyc, 1);
                if (bub_chk && !mid[c] && last_tl_cyc >= 0)
                    chk("idle_bubble", cyc - last_tl_cyc, 2);
                mid[c] = !h.l;
                if (h.l) last_tl_cyc = cyc;
            end
        end
        if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                chk("extra_beat", cur, 0);
            end else begin
                chk("beat", cur, exp_q.pop_front());
            end
            occ--;
            if (acc_cyc_q.size() > 0) begin
                a = acc_cyc_q.pop_front();
                if (lat_chk) chk("latency", cyc - a, 1);
            end
        end
        prev_stall = m_tvalid && !m_tready;
        prev_out = cur;
        cyc++;
    endtask

    task automatic run_phase(input int max_cyc, input int stop_acc);
        int left;
        cyc = 0;
        n_acc = 0;
        last_tl_cyc = -1;
        forever begin
            @(posedge axi_clk);
            #1;
            drive();
            @(negedge axi_clk);
            sample();
            if (stop_acc > 0 && n_acc >= stop_acc) break;
            left = 0;
            for (int c = 0; c < N; c++) left += src_q[c].size();
            if (exp_q.size() == 0 && occ == 0 && left == 0) break;
            if (cyc >= max_cyc) begin
                chk("timeout_left", exp_q.size() + left, 0);
                break;
            end
        end
    endtask

    task automatic set_mode(input int r, input bit g, input bit l,
                            input bit b, input bit f);
        rdy_mode = r;
        gap_en = g;
        lat_chk = l;
        bub_chk = b;
        first_chk = f;
    endtask

    initial begin
        repeat (3) @(posedge axi_clk);
        @(negedge axi_clk);
        chk("rst_tready", s_tready, 0);
        chk("rst_mvalid", m_tvalid, 0);
        chk("rst_mlast", m_tlast, 0);
        chk("rst_mdata", m_tdata, 0);
        chk("rst_mstrb", m_tstrb, 0);
        chk("rst_muser", m_tuser, 0);
        rst = 1'b0;

        load_pkt(0, 3);
        build_expected();
        set_mode(0, 0, 1, 0, 1);
        run_phase(40, 0);

        for (int p = 0; p < 2; p++)
            for (int c = 0; c < N; c++) load_pkt(c, 2);
        build_expected();
        set_mode(0, 0, 1, 1, 0);
        run_phase(80, 0);

        load_pkt(2, 6);
        load_pkt(0, 2);
        build_expected();
        set_mode(0, 1, 1, 1, 0);
        run_phase(80, 0);

        load_pkt(1, 4);
        build_expected();
        set_mode(2, 0, 0, 0, 0);
        run_phase(40, 0);

        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < N; c++)
                for (int p = $urandom_range(0, 3); p > 0; p--)
                    load_pkt(c, $urandom_range(1, 5));
            build_expected();
            set_mode(1, 1, 0, 0, 0);
            run_phase(600, 0);
        end

`ifdef DMA_AXIS_TX_RR_MUX_STATS_EN
        cnt_clr = 1'b1;
        @(negedge axi_clk);
        cnt_clr = 1'b0;
        for (int p = 0; p < 5; p++) load_pkt(1, $urandom_range(1, 3));
        build_expected();
        set_mode(0, 0, 0, 0, 0);
        run_phase(100, 0);
        chk("pkt_cnt_ch1", pkt_cnt[63:32], 5);
        cnt_clr = 1'b1;
        load_pkt(1, 1);
        build_expected();
        run_phase(20, 0);
        cnt_clr = 1'b0;
        chk("pkt_cnt_clr", pkt_cnt[63:32], 0);
`endif

        load_pkt(1, 2);
        build_expected();
        set_mode(0, 0, 0, 0, 0);
        run_phase(30, 0);
        load_pkt(2, 4);
        build_expected();
        run_phase(30, 1);
        @(posedge axi_clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_mvalid", m_tvalid, 0);
        chk("async_rst_tready", s_tready, 0);
        for (int c = 0; c < N; c++) begin
            src_q[c].delete();
            plen_q[c].delete();
            mid[c] = 0;
            pend[c] = 0;
        end
        exp_q.delete();
        acc_cyc_q.delete();
        occ = 0;
        prev_stall = 0;
        m_ptr = N - 1;
        s_tvalid = '0;
        repeat (2) @(negedge axi_clk);
        rst = 1'b0;
        load_pkt(0, 3);
        load_pkt(2, 2);
        build_expected();
        set_mode(0, 0, 1, 1, 1);
        run_phase(40, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_axis_tx_rr_mux.md
Name: dma_axis_tx_rr_mux

Overview:
Parametrised N-channel packet multiplexer between per-queue DMA MAC-tx streams and the single AXI-Stream master toward the MAC/switch fabric. It is the next generation of the single-channel MAC-tx path: a configurable channel count and data width, packet-granular round-robin arbitration, and source tagging in TUSER. Output is fully registered through a 2-entry skid slice, so input TREADY has no combinational path from M_AXIS_TREADY.

Parameters:
NUM_CH, 4, number of input channels; legal range 1..8
DATA_WIDTH, 64, TDATA width in bits; multiple of 8
TUSER_WIDTH, 128, TUSER width in bits
SRC_FIELD_LSB, 16, LSB of the 8-bit TUSER source-port field that this block overwrites

Ports:
axi_clk  in  1  sole clock
rst  in  1  reset; asynchronous, active-high
S_AXIS_TDATA  in  NUM_CH*DATA_WIDTH  channel c occupies [c*DATA_WIDTH +: DATA_WIDTH]
S_AXIS_TSTRB  in  NUM_CH*DATA_WIDTH/8  per-channel byte strobes
S_AXIS_TUSER  in  NUM_CH*TUSER_WIDTH  per-channel sideband
S_AXIS_TVALID  in  NUM_CH  per-channel valid
S_AXIS_TLAST  in  NUM_CH  per-channel end of packet
S_AXIS_TREADY  out  NUM_CH  per-channel ready
M_AXIS_TDATA  out  DATA_WIDTH  merged data
M_AXIS_TSTRB  out  DATA_WIDTH/8  merged strobes
M_AXIS_TUSER  out  TUSER_WIDTH  sideband with source field rewritten
M_AXIS_TVALID  out  1  merged valid
M_AXIS_TLAST  out  1  merged end of packet
M_AXIS_TREADY  in  1  downstream ready

Behaviour:
- Reset: all of S_AXIS_TREADY = 0, M_AXIS_TVALID = 0, M_AXIS_TLAST = 0, M_AXIS_TDATA/TSTRB/TUSER = 0. State = IDLE, grant = 0, rr_ptr = NUM_CH-1, both skid entries empty.
- FSM IDLE:
  - Scan TVALID starting at (rr_ptr+1) mod NUM_CH and wrap around.
  - The first valid channel becomes grant (registered); move to PKT.
  - If no channel is valid, stay in IDLE.
  - S_AXIS_TREADY is all-zero in IDLE, which costs exactly one bubble cycle per packet.
- FSM PKT:
  - S_AXIS_TREADY[grant] = 1 when the skid slice has at least one free entry (registered term). All other bits are 0.
  - A beat is accepted when TVALID[grant] and TREADY[grant] are both high.
  - On an accepted beat with TLAST: rr_ptr <= grant and state <= IDLE in the same edge.
  - A TLAST on the first beat is legal (single-beat packet).
  - Deasserting TVALID mid-packet holds the grant; there is no timeout.
- Tagging: TUSER[SRC_FIELD_LSB +: 8] is replaced by 8'b1 << grant. All other TUSER bits pass through unchanged.
- Skid slice:
  - 2 entries, FIFO order.
  - Latency is 1 cycle from input acceptance to M_AXIS_TVALID when the slice is empty.
  - Full throughput of 1 beat per cycle within a packet.
  - Output fields hold stable while M_AXIS_TVALID=1 and M_AXIS_TREADY=0.
  - "Free" is evaluated on registered occupancy. Simultaneous push and pop when full is not possible, because ready was already 0.
- NUM_CH=1: arbitration degenerates to grant=0 and the IDLE bubble is retained.
- Reset mid-packet: async clear of everything listed above. The partial packet is dropped with no TLAST emitted. Upstream queues are reset by the same rst.

Optional Feature:
DMA_AXIS_TX_RR_MUX_STATS_EN
- Defined:
  - Adds output port pkt_cnt (NUM_CH*32): one 32-bit wrapping counter per channel, incremented on each accepted input TLAST beat for that channel.
  - Adds input cnt_clr (1): synchronous clear of all counters. Clear wins over a same-cycle increment.
  - Counters reset to 0.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package dma_axis_pkg:
  - state encoding (ST_IDLE, ST_PKT)
  - SRC_FIELD_W = 8
  - MAX_CH = 8
  - clog2 function for the grant width
- Sub-module dma_axis_reg_slice: generic 2-entry skid buffer over {TDATA, TSTRB, TUSER, TLAST}, with its own valid/ready. Arbiter, FSM and tagging stay in the top module.

Test Plan:
- Single channel, 3-beat packet with M_AXIS_TREADY=1:
  - IDLE lasts 1 cycle, then beats appear 1 cycle after acceptance.
  - TUSER[23:16] = 8'h01; TLAST on beat 3.
- Channels 0..3 each hold 2-beat packets continuously, NUM_CH=4:
  - Output packet order is 0,1,2,3,0,... with source fields 01,02,04,08.
  - Exactly 1 idle cycle between packets.
- Channel 2 mid-packet with channel 0 asserting TVALID throughout:
  - No interleave; channel 0 is granted only after channel 2's TLAST is accepted.
- M_AXIS_TREADY toggles 1,0,0,1 during a 4-beat packet:
  - No beat is lost or duplicated; output is stable while stalled.
  - S_AXIS_TREADY drops within 1 cycle of the slice becoming full.
- rst asserted on the 2nd beat of a 4-beat packet:
  - M_AXIS_TVALID=0 and S_AXIS_TREADY=0 immediately (asynchronous).
  - After release, the next packet from channel 0 is granted first, since rr_ptr=NUM_CH-1.
- With DMA_AXIS_TX_RR_MUX_STATS_EN, 5 packets on channel 1:
  - pkt_cnt[63:32] = 5.
  - cnt_clr coinciding with a TLAST beat gives 0.
